// File: rtl/dma_pkg.sv
// Shared types and elaboration helpers for the DMA beat-to-row packer.
package dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DRAIN = 2'd3
  } dma_pack_state_e;

  function automatic int bytes_of(input int bits);
    return bits / 8;
  endfunction

  // Accumulator byte count spans 0..OB+IB-1.
  function automatic int cnt_bits(input int out_w, input int in_w);
    return $clog2(bytes_of(out_w) + bytes_of(in_w));
  endfunction

  function automatic bit widths_ok(input int in_w, input int out_w);
    return (in_w > 0) && (in_w % 8 == 0) && (out_w % 8 == 0) && (out_w >= in_w);
  endfunction

endpackage

// File: rtl/dma_pack_outreg.sv
// One-entry valid/ready output register; holds address and data while stalled.
module dma_pack_outreg #(
  parameter int DATA_W = 112,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              can_load,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign can_load  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_addr  = addr_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      addr_d  = load_addr;
      data_d  = load_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/dma_pack_gen.sv
// Packs IN_W-bit DMA beats into OUT_W-bit buffer rows, little-endian, with
// programmable row count/base and pad-or-discard handling of the stream tail.
module dma_pack_gen
  import dma_pkg::*;
#(
  parameter int IN_W   = 64,
  parameter int OUT_W  = 112,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_rows,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic              cfg_pad,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy,
  output logic              done,
  output logic              err_short,
  output dma_pack_state_e   dbg_state
);

  localparam int IB    = bytes_of(IN_W);
  localparam int OB    = bytes_of(OUT_W);
  localparam int ACC_W = (OB + IB - 1) * 8;
  localparam int CW    = cnt_bits(OUT_W, IN_W);
  localparam logic [CW-1:0] OB_C = CW'(OB);
  localparam logic [CW-1:0] IB_C = CW'(IB);

  if (!widths_ok(IN_W, OUT_W)) begin : g_bad_width
    $error("dma_pack_gen: IN_W/OUT_W must be multiples of 8 with OUT_W >= IN_W");
  end

  dma_pack_state_e   state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_sh, acc_in;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_sh, cnt_in;
  logic [CNT_W-1:0]  row_cnt_q, row_cnt_d, rows_q, rows_d, row_next;
  logic [ADDR_W-1:0] base_q, base_d, load_addr;
  logic              pad_q, pad_d, first_q, first_d, err_q, err_d, done_q, done_d;
  logic              can_load, emit_full, emit_pad, load, hs, last_row;

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err_short = err_q;
  assign dbg_state = state_q;

  // Bytes at or above cnt are always zero, so the low OUT_W bits are already
  // a correctly zero-padded row when the tail is flushed.
  always_comb begin
    emit_full = ((state_q == S_RUN) || (state_q == S_FLUSH)) && (cnt_q >= OB_C) && can_load;
    emit_pad  = (state_q == S_FLUSH) && (cnt_q < OB_C) && (cnt_q != '0) && pad_q && can_load;
    load      = emit_full || emit_pad;
    in_ready  = (state_q == S_RUN) && ((cnt_q < OB_C) || emit_full);
    hs        = in_valid && in_ready;
    row_next  = row_cnt_q + CNT_W'(1);
    last_row  = (row_next == rows_q);
    acc_sh    = emit_full ? (acc_q >> OUT_W) : acc_q;
    cnt_sh    = emit_full ? (cnt_q - OB_C) : cnt_q;
    acc_in    = acc_sh | (ACC_W'(in_data) << {cnt_sh, 3'b000});
    cnt_in    = cnt_sh + IB_C;
    load_addr = first_q ? base_q : (out_addr + ADDR_W'(1));

    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    row_cnt_d = row_cnt_q;
    rows_d    = rows_q;
    base_d    = base_q;
    pad_d     = pad_q;
    first_d   = first_q;
    err_d     = err_q;
    done_d    = 1'b0;

    if (load) begin
      row_cnt_d = row_next;
      first_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          acc_d     = '0;
          cnt_d     = '0;
          row_cnt_d = '0;
          err_d     = 1'b0;
          rows_d    = (cfg_rows == '0) ? CNT_W'(1) : cfg_rows;
          base_d    = cfg_base;
          pad_d     = cfg_pad;
          first_d   = 1'b1;
        end
      end
      S_RUN: begin
        if (emit_full && last_row) begin
          state_d = S_DRAIN;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (hs) begin
          acc_d = acc_in;
          cnt_d = cnt_in;
          // Full rows still pending after the last beat go out via FLUSH even
          // without padding; only a sub-row remainder is short immediately.
          if (in_last) begin
            if (cfg_pad_or_full(pad_q, cnt_in >= OB_C)) begin
              state_d = S_FLUSH;
            end else begin
              state_d = S_DRAIN;
              err_d   = 1'b1;
              acc_d   = '0;
              cnt_d   = '0;
            end
          end
        end else begin
          acc_d = acc_sh;
          cnt_d = cnt_sh;
        end
      end
      S_FLUSH: begin
        if (emit_full) begin
          if (last_row) begin
            state_d = S_DRAIN;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            acc_d = acc_sh;
            cnt_d = cnt_sh;
          end
        end else if (cnt_q < OB_C) begin
          if (emit_pad) begin
            state_d = S_DRAIN;
            acc_d   = '0;
            cnt_d   = '0;
            err_d   = err_q || !last_row;
          end else if ((cnt_q == '0) || !pad_q) begin
            state_d = S_DRAIN;
            acc_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (can_load) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  function automatic logic cfg_pad_or_full(input logic pad, input logic full_pending);
    return pad || full_pending;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      row_cnt_q <= '0;
      rows_q    <= '0;
      base_q    <= '0;
      pad_q     <= 1'b0;
      first_q   <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      row_cnt_q <= row_cnt_d;
      rows_q    <= rows_d;
      base_q    <= base_d;
      pad_q     <= pad_d;
      first_q   <= first_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  dma_pack_outreg #(.DATA_W(OUT_W), .ADDR_W(ADDR_W)) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_addr (load_addr),
    .load_data (acc_q[OUT_W-1:0]),
    .out_ready (out_ready),
    .can_load  (can_load),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_dma_pack_gen.sv
// Bench for dma_pack_gen: a 64->112 instance and a 32->96 instance, each with
// a row scoreboard fed by the stimulus tasks and drained by a monitor.
module tb_dma_pack_gen;
  import dma_pkg::*;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are both high.

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, start_a, cfg_pad_a, in_valid_a, in_last_a, out_ready_a;
  logic [7:0] cfg_rows_a;
  logic [9:0] cfg_base_a, out_addr_a;
  logic [63:0] in_data_a;
  logic [111:0] out_data_a;
  logic in_ready_a, out_valid_a, busy_a, done_a, err_a;
  dma_pack_state_e dbg_a;

  logic rst_b, start_b, cfg_pad_b, in_valid_b, in_last_b, out_ready_b;
  logic [7:0] cfg_rows_b;
  logic [9:0] cfg_base_b, out_addr_b;
  logic [31:0] in_data_b;
  logic [95:0] out_data_b;
  logic in_ready_b, out_valid_b, busy_b, done_b, err_b;
  dma_pack_state_e dbg_b;

  dma_pack_gen #(.IN_W(64), .OUT_W(112), .ADDR_W(10), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .cfg_rows(cfg_rows_a), .cfg_base(cfg_base_a),
    .cfg_pad(cfg_pad_a), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .in_last(in_last_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .out_addr(out_addr_a),
    .out_data(out_data_a), .busy(busy_a), .done(done_a), .err_short(err_a), .dbg_state(dbg_a)
  );

  dma_pack_gen #(.IN_W(32), .OUT_W(96), .ADDR_W(10), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .cfg_rows(cfg_rows_b), .cfg_base(cfg_base_b),
    .cfg_pad(cfg_pad_b), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .in_last(in_last_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_addr(out_addr_b),
    .out_data(out_data_b), .busy(busy_b), .done(done_b), .err_short(err_b), .dbg_state(dbg_b)
  );

  int errors = 0;
  int checks = 0;
  logic [121:0] exp_qa[$];
  logic [105:0] exp_qb[$];
  int rows_seen_a = 0, rows_seen_b = 0, done_cnt_a = 0, done_cnt_b = 0;

  logic rnd_a = 1'b0;
  logic rnd_bit_a = 1'b1;
  assign out_ready_a = rnd_a ? rnd_bit_a : 1'b1;
  always @(posedge clk) rnd_bit_a <= ($urandom_range(0, 9) >= 3);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [111:0] make_row(input int s, input int first, input int nbytes, input int ob);
    logic [111:0] r = '0;
    for (int j = 0; j < ob; j++)
      if (first + j < nbytes) r[8*j +: 8] = 8'(s + first + j);
    return r;
  endfunction

  function automatic logic [63:0] beat_bytes(input int s, input int pos, input int ib);
    logic [63:0] r = '0;
    for (int j = 0; j < ib; j++) r[8*j +: 8] = 8'(s + pos + j);
    return r;
  endfunction

  // Reference: full rows up to the block length, then one zero-padded tail row if allowed.
  task automatic push_exp(input bit is_a, input int s, input int nbytes, input int rows,
                          input int base, input bit pad);
    int ob = is_a ? 14 : 12;
    int re = (rows == 0) ? 1 : rows;
    int full = nbytes / ob;
    int n = (full < re) ? full : re;
    logic [111:0] r;
    for (int k = 0; k <= n; k++) begin
      if (k < n || (n < re && pad && (nbytes % ob) != 0)) begin
        r = make_row(s, ob * k, nbytes, ob);
        if (is_a) exp_qa.push_back({10'(base + k), r});
        else      exp_qb.push_back({10'(base + k), r[95:0]});
      end
    end
  endtask

  // Monitor A: scoreboard pop, row hold under stall, done counting.
  logic stall_a = 1'b0;
  logic [9:0] hold_addr_a;
  logic [111:0] hold_data_a;
  always @(negedge clk) begin
    if (done_a) done_cnt_a++;
    if (stall_a) check("hold_a", {out_valid_a, out_addr_a, out_data_a}, {1'b1, hold_addr_a, hold_data_a});
    if (out_valid_a && out_ready_a) begin
      rows_seen_a++;
      if (exp_qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL row_a: unexpected row addr %0d data %h", out_addr_a, out_data_a);
      end else begin
        check("row_a", {out_addr_a, out_data_a}, exp_qa.pop_front());
      end
    end
    stall_a     = out_valid_a && !out_ready_a && !rst_a;
    hold_addr_a = out_addr_a;
    hold_data_a = out_data_a;
  end

  always @(negedge clk) begin
    if (done_b) done_cnt_b++;
    if (out_valid_b && out_ready_b) begin
      rows_seen_b++;
      if (exp_qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL row_b: unexpected row addr %0d data %h", out_addr_b, out_data_b);
      end else begin
        check("row_b", {out_addr_b, out_data_b}, exp_qb.pop_front());
      end
    end
  end

  task automatic send_beat_a(input logic [63:0] d, input logic last);
    int n = 0;
    in_data_a = d; in_last_a = last; in_valid_a = 1'b1;
    @(negedge clk);
    while (!in_ready_a && n < 300) begin n++; @(negedge clk); end
    if (!in_ready_a) begin checks++; errors++; $display("FAIL beat_a: in_ready low for %0d cycles", n); end
    @(posedge clk); #1;
    in_valid_a = 1'b0; in_last_a = 1'b0;
  endtask

  task automatic send_beat_b(input logic [31:0] d, input logic last);
    int n = 0;
    in_data_b = d; in_last_b = last; in_valid_b = 1'b1;
    @(negedge clk);
    while (!in_ready_b && n < 300) begin n++; @(negedge clk); end
    if (!in_ready_b) begin checks++; errors++; $display("FAIL beat_b: in_ready low for %0d cycles", n); end
    @(posedge clk); #1;
    in_valid_b = 1'b0; in_last_b = 1'b0;
  endtask

  task automatic run_block_a(input string tag, input int rows, input int base, input bit pad,
                             input int nbeats, input int s, input bit exp_err, input int exp_rows,
                             input bit poke);
    int d0 = done_cnt_a;
    int r0 = rows_seen_a;
    int n = 0;
    push_exp(1'b1, s, nbeats * 8, rows, base, pad);
    cfg_rows_a = 8'(rows); cfg_base_a = 10'(base); cfg_pad_a = pad; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check({tag, "_busy"}, 128'(busy_a), 128'(1));
    for (int b = 0; b < nbeats; b++) begin
      if (poke && b == 10) begin start_a = 1'b1; cfg_base_a = 10'd500; end
      send_beat_a(beat_bytes(s, 8 * b, 8), b == nbeats - 1);
      start_a = 1'b0; cfg_base_a = 10'(base);
    end
    while (!done_a && n < 3000) begin n++; @(negedge clk); end
    if (!done_a) begin checks++; errors++; $display("FAIL %s_done: no done within %0d cycles", tag, n); end
    repeat (3) @(negedge clk);
    check({tag, "_done_cnt"}, 128'(done_cnt_a - d0), 128'(1));
    check({tag, "_err"}, 128'(err_a), 128'(exp_err));
    check({tag, "_rows"}, 128'(rows_seen_a - r0), 128'(exp_rows));
    check({tag, "_left"}, 128'(exp_qa.size()), 128'(0));
    check({tag, "_idle"}, {busy_a, 6'(dbg_a)}, {1'b0, 6'(S_IDLE)});
    @(posedge clk); #1;
  endtask

  task automatic run_block_b(input string tag, input int rows, input int base, input int nbeats,
                             input int s, input int exp_rows);
    int d0 = done_cnt_b;
    int r0 = rows_seen_b;
    int n = 0;
    push_exp(1'b0, s, nbeats * 4, rows, base, 1'b1);
    cfg_rows_b = 8'(rows); cfg_base_b = 10'(base); cfg_pad_b = 1'b1; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int b = 0; b < nbeats; b++) send_beat_b(32'(beat_bytes(s, 4 * b, 4)), b == nbeats - 1);
    while (!done_b && n < 3000) begin n++; @(negedge clk); end
    if (!done_b) begin checks++; errors++; $display("FAIL %s_done: no done within %0d cycles", tag, n); end
    repeat (3) @(negedge clk);
    check({tag, "_done_cnt"}, 128'(done_cnt_b - d0), 128'(1));
    check({tag, "_err"}, 128'(err_b), 128'(0));
    check({tag, "_rows"}, 128'(rows_seen_b - r0), 128'(exp_rows));
    check({tag, "_left"}, 128'(exp_qb.size()), 128'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst_a = 1'b1; start_a = 1'b0; cfg_rows_a = '0; cfg_base_a = '0; cfg_pad_a = 1'b0;
    in_valid_a = 1'b0; in_last_a = 1'b0; in_data_a = '0;
    rst_b = 1'b1; start_b = 1'b0; cfg_rows_b = '0; cfg_base_b = '0; cfg_pad_b = 1'b0;
    in_valid_b = 1'b0; in_last_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("reset_a", {in_ready_a, out_valid_a, out_addr_a, out_data_a, busy_a, done_a, err_a, 2'(dbg_a)}, '0);
    check("reset_b", {in_ready_b, out_valid_b, out_addr_b, out_data_b, busy_b, done_b, err_b, 2'(dbg_b)}, '0);
    @(posedge clk); #1;

    // 25 beats, 14 rows; bytes 0xC4..0xC7 dropped; a start pulse mid-block is ignored.
    run_block_a("full", 14, 0, 1'b1, 25, 0, 1'b0, 14, 1'b1);
    rnd_a = 1'b1;
    run_block_a("stall", 14, 0, 1'b1, 25, 0, 1'b0, 14, 1'b0);
    rnd_a = 1'b0;
    run_block_a("pad", 4, 0, 1'b1, 6, 0, 1'b0, 4, 1'b0);
    run_block_a("short", 8, 0, 1'b0, 6, 0, 1'b1, 3, 1'b0);
    run_block_a("wrap", 4, 1022, 1'b1, 7, 8'h30, 1'b0, 4, 1'b0);
    run_block_a("rows0", 0, 9, 1'b0, 2, 8'h55, 1'b0, 1, 1'b0);
    run_block_a("zero", 4, 3, 1'b0, 1, 8'h11, 1'b1, 0, 1'b0);
    run_block_a("clear", 2, 100, 1'b1, 4, 8'hA0, 1'b0, 2, 1'b0);

    run_block_b("b_full", 3, 0, 9, 0, 3);

    // Aborted block: first row stalls in the output register, then reset.
    d0 = done_cnt_b;
    out_ready_b = 1'b0;
    cfg_rows_b = 8'd3; cfg_base_b = 10'd5; cfg_pad_b = 1'b1; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int b = 0; b < 4; b++) send_beat_b(32'(beat_bytes(8'h80, 4 * b, 4)), 1'b0);
    @(negedge clk);
    check("b_pending", {out_valid_b, out_addr_b, busy_b}, {1'b1, 10'd5, 1'b1});
    @(posedge clk); #1;
    rst_b = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst_b = 1'b0;
    @(negedge clk);
    check("b_rst", {in_ready_b, out_valid_b, out_addr_b, out_data_b, busy_b, done_b, err_b, 2'(dbg_b)}, '0);
    check("b_rst_nodone", 128'(done_cnt_b - d0), 128'(0));
    @(posedge clk); #1;
    out_ready_b = 1'b1;
    run_block_b("b_clean", 3, 7, 9, 8'h40, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
